// File: rtl/rr_mux_arbiter_16.sv
// Round-robin arbiter for a 16:1 bit-select datapath: grants one requester per burst and registers its bit.
// Optional macro RR_ARB_BACK2BACK_EN: re-arbitrate at burst end so the grant moves without an IDLE gap.
module rr_mux_arbiter_16 #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic [15:0] data_in,
    output logic [3:0]  select,
    output logic [15:0] grant,
    output logic        busy,
    output logic        data_out,
    output logic        data_valid,
    output logic        burst_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  select_q, select_d;
    logic [15:0] grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        burst_done_q, burst_done_d;
    logic        end_grant;

    logic        idle_found;
    logic [3:0]  idle_win;

    // First requester found scanning start, start+1, ... with 4-bit wraparound.
    function automatic logic [4:0] rr_pick(input logic [3:0] start, input logic [15:0] r);
        logic       found;
        logic [3:0] win;
        logic [3:0] idx;
        found = 1'b0;
        win   = start;
        for (int i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    assign {idle_found, idle_win} = rr_pick(ptr_q, req);

`ifdef RR_ARB_BACK2BACK_EN
    logic        next_found;
    logic [3:0]  next_win;
    assign {next_found, next_win} = rr_pick(select_q + 4'd1, req);
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        select_d     = select_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        burst_done_d = 1'b0;
        end_grant    = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_found) begin
                    select_d = idle_win;
                    grant_d  = 16'd1 << idle_win;
                    cnt_d    = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (req[select_q]) begin
                    data_out_d   = data_in[select_q];
                    data_valid_d = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        burst_done_d = 1'b1;
                        end_grant    = 1'b1;
                    end
                end else begin
                    // Early release: the owner dropped its request, give up the channel.
                    end_grant = 1'b1;
                end
                if (end_grant) begin
                    ptr_d   = select_q + 4'd1;
                    grant_d = '0;
                    state_d = IDLE;
`ifdef RR_ARB_BACK2BACK_EN
                    if (next_found) begin
                        select_d = next_win;
                        grant_d  = 16'd1 << next_win;
                        cnt_d    = '0;
                        state_d  = GRANT;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            select_q     <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            select_q     <= select_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign select     = select_q;
    assign grant      = grant_q;
    assign busy       = (state_q == GRANT);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_rr_mux_arbiter_16.sv
// Directed bench for rr_mux_arbiter_16 (BURST_LEN=4); expected grants and bits are hand-derived.
module tb_rr_mux_arbiter_16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] data_in;
    logic [3:0]  select;
    logic [15:0] grant;
    logic        busy;
    logic        data_out;
    logic        data_valid;
    logic        burst_done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int bd_count  = 0;

    rr_mux_arbiter_16 #(.BURST_LEN(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .select     (select),
        .grant      (grant),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .burst_done (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bd_count += int'(burst_done);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One IDLE->GRANT edge: grant/select appear, no data yet.
    task automatic expect_grant(input int k, input string tag);
        step();
        check({tag, "_grant"}, grant, 16'd1 << k);
        check({tag, "_select"}, {12'd0, select}, 16'(k));
        check({tag, "_busy"}, {15'd0, busy}, 16'd1);
        check({tag, "_dv0"}, {15'd0, data_valid}, 16'd0);
    endtask

`ifndef RR_ARB_BACK2BACK_EN
    // Four sampled bits; other requesters' data_in bits are driven opposite to catch leakage.
    task automatic run_burst(input int k, input logic [3:0] bits, input string tag);
        logic [15:0] onehot;
        onehot = 16'd1 << k;
        for (int b = 0; b < 4; b++) begin
            data_in = bits[b] ? onehot : ~onehot;
            step();
            check({tag, "_dv"}, {15'd0, data_valid}, 16'd1);
            check({tag, "_dout"}, {15'd0, data_out}, {15'd0, bits[b]});
            if (b < 3) begin
                check({tag, "_bd_mid"}, {15'd0, burst_done}, 16'd0);
                check({tag, "_grant_mid"}, grant, onehot);
            end else begin
                check({tag, "_bd_end"}, {15'd0, burst_done}, 16'd1);
                check({tag, "_grant_end"}, grant, 16'd0);
                check({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
            end
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        req     = 16'd0;
        data_in = 16'd0;
        @(posedge clk);
        #1;
        check("rst_select", {12'd0, select}, 16'd0);
        check("rst_grant", grant, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_dout", {15'd0, data_out}, 16'd0);
        check("rst_dv", {15'd0, data_valid}, 16'd0);
        check("rst_bd", {15'd0, burst_done}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

`ifndef RR_ARB_BACK2BACK_EN
        // Lone requester 5, bits 1,0,1,1, then re-grant after one gap cycle.
        req = 16'h0020;
        expect_grant(5, "t1");
        run_burst(5, 4'b1101, "t1");
        expect_grant(5, "t1_regrant");
        check("t1_dout_hold", {15'd0, data_out}, 16'd1);
        req = 16'h0000;
        step();
        check("t1_rel_grant", grant, 16'd0);
        check("t1_rel_dv", {15'd0, data_valid}, 16'd0);
        check("t1_rel_bd", {15'd0, burst_done}, 16'd0);

        // Full rotation with every requester active.
        apply_reset();
        req      = 16'hFFFF;
        bd_count = 0;
        for (int k = 0; k < 16; k++) begin
            expect_grant(k, "t2");
            run_burst(k, 4'(k) ^ 4'b0110, "t2");
        end
        check("t2_bd_count", 16'(bd_count), 16'd16);
        expect_grant(0, "t2_wrap");
        run_burst(0, 4'b0011, "t2_wrap");

        // Wraparound 14 -> 15 -> 0 -> 15.
        req = 16'h4000;
        expect_grant(14, "t3_a");
        run_burst(14, 4'b1001, "t3_a");
        req = 16'h8001;
        expect_grant(15, "t3_b");
        run_burst(15, 4'b0101, "t3_b");
        expect_grant(0, "t3_c");
        run_burst(0, 4'b1110, "t3_c");
        expect_grant(15, "t3_d");
        run_burst(15, 4'b0111, "t3_d");

        // Early release after two bits.
        req = 16'h0009;
        expect_grant(0, "t4");
        data_in = 16'h0001;
        step();
        check("t4_dv1", {15'd0, data_valid}, 16'd1);
        check("t4_dout1", {15'd0, data_out}, 16'd1);
        data_in = 16'hFFFE;
        step();
        check("t4_dv2", {15'd0, data_valid}, 16'd1);
        check("t4_dout2", {15'd0, data_out}, 16'd0);
        check("t4_bd2", {15'd0, burst_done}, 16'd0);
        req     = 16'h0008;
        data_in = 16'hFFFF;
        step();
        check("t4_rel_dv", {15'd0, data_valid}, 16'd0);
        check("t4_rel_bd", {15'd0, burst_done}, 16'd0);
        check("t4_rel_grant", grant, 16'd0);
        check("t4_rel_dout", {15'd0, data_out}, 16'd0);
        expect_grant(3, "t4_next");
        run_burst(3, 4'b1010, "t4_next");

        // Asynchronous reset in the middle of a burst to 7.
        req = 16'h0080;
        expect_grant(7, "t5");
        data_in = 16'h0080;
        step();
        check("t5_dv1", {15'd0, data_valid}, 16'd1);
        check("t5_dout1", {15'd0, data_out}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_select", {12'd0, select}, 16'd0);
        check("t5_rst_grant", grant, 16'd0);
        check("t5_rst_busy", {15'd0, busy}, 16'd0);
        check("t5_rst_dout", {15'd0, data_out}, 16'd0);
        check("t5_rst_dv", {15'd0, data_valid}, 16'd0);
        check("t5_rst_bd", {15'd0, burst_done}, 16'd0);
        req = 16'h0090;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_grant(4, "t5_after");
        run_burst(4, 4'b0110, "t5_after");
        req = 16'h0000;
        step();
        check("t5_idle_grant", grant, 16'd0);
`else
        // Back-to-back: grant hops 0 -> 1 -> 0 with data_valid continuously high.
        req = 16'h0003;
        expect_grant(0, "t6");
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 4; b++) begin
                data_in = (b[0] ^ g[0]) ? (16'd1 << g) : ~(16'd1 << g);
                step();
                check("t6_dv", {15'd0, data_valid}, 16'd1);
                check("t6_dout", {15'd0, data_out}, {15'd0, b[0] ^ g[0]});
                check("t6_busy", {15'd0, busy}, 16'd1);
                check("t6_bd", {15'd0, burst_done}, (b == 3) ? 16'd1 : 16'd0);
                check("t6_grant", grant, (b == 3) ? (16'd1 << (1 - g)) : (16'd1 << g));
            end
        end
        req = 16'h0000;
        step();
        step();
        check("t6_idle_grant", grant, 16'd0);
        check("t6_idle_busy", {15'd0, busy}, 16'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
